// File: rtl/fsm_ex1_pkg.sv
// Shared encodings for the ex1 a/b handshake driver and its responder.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package fsm_ex1_pkg;

    // Command encodings carried on cmd
    localparam logic [1:0] CMD_NOP   = 2'b00;
    localparam logic [1:0] CMD_SHORT = 2'b01;
    localparam logic [1:0] CMD_LONG  = 2'b10;
    localparam logic [1:0] CMD_RSVD  = 2'b11;

    // Responder state encodings (y1=1 in S0,S1; y0 = S0 & a & b)
    localparam logic [1:0] RSP_S0 = 2'b00;
    localparam logic [1:0] RSP_S1 = 2'b01;
    localparam logic [1:0] RSP_S2 = 2'b10;

    // Hold counter width, fixed independently of WAIT_CYCLES
    localparam int HOLD_W = 8;

    // Driver states
    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_NOP      = 3'd1,
        ST_SH_FIRE  = 3'd2,
        ST_SH_GAP   = 3'd3,
        ST_LG_ENTER = 3'd4,
        ST_LG_HOLD  = 3'd5,
        ST_LG_EXIT  = 3'd6,
        ST_BAD      = 3'd7
    } drv_state_t;

    // Moore decode of {a,b} from the driver state
    function automatic logic [1:0] drive_ab(input drv_state_t s);
        logic [1:0] ab;
        ab = 2'b00;
        case (s)
            ST_SH_FIRE:  ab = 2'b11;
            ST_LG_ENTER: ab = 2'b10;
            ST_LG_EXIT:  ab = 2'b10;
            default:     ab = 2'b00;
        endcase
        return ab;
    endfunction

    // Expected responder outputs for the current drive cycle; BAD never passes
    function automatic logic check_ok(input drv_state_t s, input logic y1, input logic y0);
        logic ok;
        ok = 1'b1;
        case (s)
            ST_NOP:      ok = y1 & ~y0;
            ST_SH_FIRE:  ok = y1 & y0;
            ST_SH_GAP:   ok = ~y1;
            ST_LG_ENTER: ok = y1 & ~y0;
            ST_LG_HOLD:  ok = y1;
            ST_LG_EXIT:  ok = y1 & ~y0;
            ST_BAD:      ok = 1'b0;
            default:     ok = 1'b1;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/ex1_hold_counter.sv
// Down-counter timing the LG_HOLD phase: load, decrement, zero flag.
// Latency: loaded value visible the cycle after load_i; zero_o is combinational on the count.
// Backpressure: none; load_i takes priority over dec_i.
module ex1_hold_counter
    import fsm_ex1_pkg::*;
#(
    parameter int W = HOLD_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] load_val_i,
    input  logic         dec_i,
    output logic         zero_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // Next count: load wins, otherwise decrement while non-zero
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Count register, cleared by async reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/fsm_ex1_driver.sv
// Initiator for the ex1 a/b handshake: runs one command, checks y0/y1, reports done/err.
// Latency: done 2 (NOP/RSVD), 3 (SHORT) or 3+WAIT_CYCLES (LONG) cycles after accept.
// Backpressure: cmd_ready is high only in IDLE; next command may be accepted in the done cycle.
module fsm_ex1_driver
    import fsm_ex1_pkg::*;
#(
    parameter int WAIT_CYCLES = 2,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    input  logic [1:0]       cmd,
    output logic             cmd_ready,
    output logic             a,
    output logic             b,
    input  logic             y0,
    input  logic             y1,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             err_sticky,
    output logic [CNT_W-1:0] txn_count
);

    localparam logic              HAS_HOLD  = (WAIT_CYCLES != 0);
    localparam logic [HOLD_W-1:0] HOLD_LOAD = HAS_HOLD ? HOLD_W'(WAIT_CYCLES - 1) : '0;

    drv_state_t       state_q, state_d;
    logic             fail_q, fail_d;
    logic             done_q, err_q, err_sticky_q;
    logic [CNT_W-1:0] txn_count_q;

    logic             chk_ok;
    logic             finish;
    logic             hold_load;
    logic             hold_dec;
    logic             hold_zero;
    logic [1:0]       ab;

    ex1_hold_counter #(
        .W (HOLD_W)
    ) u_hold (
        .clk        (clk),
        .reset      (reset),
        .load_i     (hold_load),
        .load_val_i (HOLD_LOAD),
        .dec_i      (hold_dec),
        .zero_o     (hold_zero)
    );

    // Next-state, fail accumulation and hold-counter control
    always_comb begin
        state_d   = state_q;
        fail_d    = fail_q;
        hold_load = 1'b0;
        hold_dec  = 1'b0;
        finish    = 1'b0;
        chk_ok    = check_ok(state_q, y1, y0);
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    fail_d = 1'b0;
                    case (cmd)
                        CMD_NOP:   state_d = ST_NOP;
                        CMD_SHORT: state_d = ST_SH_FIRE;
                        CMD_LONG:  state_d = ST_LG_ENTER;
                        default:   state_d = ST_BAD;
                    endcase
                end
            end
            ST_NOP: begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_SH_FIRE: begin
                state_d = ST_SH_GAP;
            end
            ST_SH_GAP: begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_LG_ENTER: begin
                if (HAS_HOLD) begin
                    state_d   = ST_LG_HOLD;
                    hold_load = 1'b1;
                end else begin
                    state_d = ST_LG_EXIT;
                end
            end
            ST_LG_HOLD: begin
                if (hold_zero) begin
                    state_d = ST_LG_EXIT;
                end else begin
                    hold_dec = 1'b1;
                end
            end
            ST_LG_EXIT: begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            ST_BAD: begin
                finish  = 1'b1;
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        // Checks only flag; they never shorten a sequence
        if (state_q != ST_IDLE) begin
            fail_d = fail_q | ~chk_ok;
        end
    end

    // FSM state plus registered done/err/sticky/count, updated on final-state exit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            fail_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            err_sticky_q <= 1'b0;
            txn_count_q  <= '0;
        end else begin
            state_q <= state_d;
            fail_q  <= fail_d;
            done_q  <= finish;
            err_q   <= finish & fail_d;
            if (finish) begin
                txn_count_q  <= txn_count_q + {{(CNT_W-1){1'b0}}, 1'b1};
                err_sticky_q <= err_sticky_q | fail_d;
            end
        end
    end

    assign ab         = drive_ab(state_q);
    assign a          = ab[1];
    assign b          = ab[0];
    assign cmd_ready  = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);
    assign done       = done_q;
    assign err        = err_q;
    assign err_sticky = err_sticky_q;
    assign txn_count  = txn_count_q;

endmodule
